// File: rtl/sd2snes_map_pkg.sv
// sd2snes_map_pkg: address class enum and default map constants shared by the SPC7110 mapper
package sd2snes_map_pkg;
  typedef enum logic [2:0] {CLS_NONE, CLS_SRAM, CLS_PROM, CLS_DROM, CLS_ROM} cls_t;
  localparam logic [15:0] DEF_REG_BASE = 16'h4830;
  localparam logic [23:0] DEF_SAVERAM_BASE = 24'hE00000;
endpackage

// File: rtl/spc7110_bank_regs.sv
// spc7110_bank_regs: SRAM-enable and DROM bank registers with MMIO write decode and readback
// Ports: clk/rst (async, active-high); a22 and addr = SNES_ADDR[22] and SNES_ADDR[15:0];
// wr/data = MMIO write strobe and data; reg_hit/reg_data = combinational decode and readback;
// sram_en = save RAM enable; block_out = bank registers, window 0 in the LSBs.
module spc7110_bank_regs
  import sd2snes_map_pkg::*;
#(
  parameter int NUM_WIN = 3,
  parameter int BLK_W = 3,
  parameter logic [15:0] REG_BASE = DEF_REG_BASE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     a22,
  input  logic [15:0]              addr,
  input  logic                     wr,
  input  logic [7:0]               data,
  output logic                     reg_hit,
  output logic [7:0]               reg_data,
  output logic                     sram_en,
  output logic [NUM_WIN*BLK_W-1:0] block_out
);
  logic [15:0] off;
  // Addresses below REG_BASE wrap to large offsets and fall outside the window.
  assign off = addr - REG_BASE;
  assign reg_hit = !a22 && off <= 16'(NUM_WIN);
  always_comb begin
    reg_data = 8'h00;
    if (reg_hit && off == 16'd0) reg_data = {sram_en, 7'b0};
    for (int i = 0; i < NUM_WIN; i++)
      if (reg_hit && off == 16'(i + 1)) reg_data = 8'(block_out[i*BLK_W +: BLK_W]);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sram_en <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) block_out[i*BLK_W +: BLK_W] <= BLK_W'(i);
    end else if (wr && reg_hit) begin
      if (off == 16'd0) sram_en <= data[7];
      for (int i = 0; i < NUM_WIN; i++)
        if (off == 16'(i + 1)) block_out[i*BLK_W +: BLK_W] <= data[BLK_W-1:0];
    end
endmodule

// File: rtl/spc7110_bank_mapper.sv
// spc7110_bank_mapper: 2-stage SNES-to-PSRAM address translator with bank-switched DROM windows
// Ports: CLK/RST (async, active-high); SNES_ADDR/SNES_DATA_IN/REQ/REG_WR from the bus front end;
// SAVERAM_MASK/ROM_MASK size masks; ROM_ADDR/ROM_HIT/IS_SAVERAM qualified by ADDR_VALID (2-cycle
// latency); REG_HIT/REG_DATA_OUT combinational register readback; BLOCK_OUT current bank registers.
module spc7110_bank_mapper
  import sd2snes_map_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int NUM_WIN = 3,
  parameter int BLK_W = 3,
  parameter logic [15:0] REG_BASE = DEF_REG_BASE,
  parameter logic [ADDR_W-1:0] SAVERAM_BASE = ADDR_W'(DEF_SAVERAM_BASE)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDR_W-1:0]        SNES_ADDR,
  input  logic [7:0]               SNES_DATA_IN,
  input  logic                     REQ,
  input  logic                     REG_WR,
  input  logic [ADDR_W-1:0]        SAVERAM_MASK,
  input  logic [ADDR_W-1:0]        ROM_MASK,
  output logic [ADDR_W-1:0]        ROM_ADDR,
  output logic                     ROM_HIT,
  output logic                     IS_SAVERAM,
  output logic                     ADDR_VALID,
  output logic                     REG_HIT,
  output logic [7:0]               REG_DATA_OUT,
  output logic [NUM_WIN*BLK_W-1:0] BLOCK_OUT
);
  localparam int HI_W = ADDR_W - 20;
  logic sram_en;
  logic [1:0] q;
  cls_t cls, s1_cls;
  logic [BLK_W-1:0] blk_sel, s1_blk;
  logic [BLK_W:0] blk_inc;
  logic [21:0] s1_addr;
  logic s1_v;
  logic [ADDR_W-1:0] xlat;
  spc7110_bank_regs #(.NUM_WIN(NUM_WIN), .BLK_W(BLK_W), .REG_BASE(REG_BASE)) u_regs (
    .CLK(CLK), .RST(RST), .a22(SNES_ADDR[22]), .addr(SNES_ADDR[15:0]), .wr(REG_WR),
    .data(SNES_DATA_IN), .reg_hit(REG_HIT), .reg_data(REG_DATA_OUT), .sram_en(sram_en),
    .block_out(BLOCK_OUT)
  );
  always_comb begin
    q = SNES_ADDR[21:20];
    // Quarters beyond the implemented windows map fixed, as if their bank were q-1.
    blk_sel = BLK_W'(q - 2'd1);
    for (int i = 0; i < NUM_WIN; i++)
      if (int'(q) == i + 1) blk_sel = BLOCK_OUT[i*BLK_W +: BLK_W];
    cls = (sram_en && SAVERAM_MASK[0] && !SNES_ADDR[22] && SNES_ADDR[21] && !SNES_ADDR[15]
           && &SNES_ADDR[14:13]) ? CLS_SRAM
        : (SNES_ADDR[23:22] == 2'b11) ? (q == 2'd0 ? CLS_PROM : CLS_DROM)
        : (!SNES_ADDR[22] && SNES_ADDR[15]) ? CLS_ROM : CLS_NONE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1_v <= 1'b0;
      s1_addr <= '0;
      s1_cls <= CLS_NONE;
      s1_blk <= '0;
    end else begin
      s1_v <= REQ;
      if (REQ) begin
        s1_addr <= SNES_ADDR[21:0];
        s1_cls <= cls;
        s1_blk <= blk_sel;
      end
    end
  always_comb begin
    blk_inc = {1'b0, s1_blk} + 1'b1;
    xlat = s1_cls == CLS_SRAM ? SAVERAM_BASE + (ADDR_W'({s1_addr[20:16], s1_addr[12:0]}) & SAVERAM_MASK)
         : s1_cls == CLS_PROM ? ADDR_W'(s1_addr[20:0]) & ROM_MASK
         : s1_cls == CLS_DROM ? {HI_W'(blk_inc), s1_addr[19:0]} & ROM_MASK
         : s1_cls == CLS_ROM  ? ADDR_W'(s1_addr[21:0]) & ROM_MASK : '0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ADDR_VALID <= 1'b0;
      ROM_ADDR <= '0;
      ROM_HIT <= 1'b0;
      IS_SAVERAM <= 1'b0;
    end else begin
      ADDR_VALID <= s1_v;
      if (s1_v) begin
        ROM_ADDR <= xlat;
        ROM_HIT <= s1_cls != CLS_NONE;
        IS_SAVERAM <= s1_cls == CLS_SRAM;
      end
    end
endmodule

// File: tb/tb_spc7110_bank_mapper.sv
// tb_spc7110_bank_mapper: directed and random checks of two mapper instances (3 and 1 windows)
module tb_spc7110_bank_mapper;
  logic CLK = 1'b0, RST = 1'b1, REQ = 1'b0, REG_WR = 1'b0;
  logic [23:0] SNES_ADDR = '0, SAVERAM_MASK = '0, ROM_MASK = 24'hFFFFFF;
  logic [7:0] SNES_DATA_IN = '0;
  logic [23:0] ra3, ra1;
  logic hit3, hit1, sv3, sv1, av3, av1, rh3, rh1;
  logic [7:0] rd3, rd1;
  logic [8:0] bo3;
  logic [2:0] bo1;

  always #5 CLK = ~CLK;

  spc7110_bank_mapper dut3 (
    .CLK(CLK), .RST(RST), .SNES_ADDR(SNES_ADDR), .SNES_DATA_IN(SNES_DATA_IN), .REQ(REQ),
    .REG_WR(REG_WR), .SAVERAM_MASK(SAVERAM_MASK), .ROM_MASK(ROM_MASK), .ROM_ADDR(ra3),
    .ROM_HIT(hit3), .IS_SAVERAM(sv3), .ADDR_VALID(av3), .REG_HIT(rh3), .REG_DATA_OUT(rd3),
    .BLOCK_OUT(bo3)
  );
  spc7110_bank_mapper #(.NUM_WIN(1)) dut1 (
    .CLK(CLK), .RST(RST), .SNES_ADDR(SNES_ADDR), .SNES_DATA_IN(SNES_DATA_IN), .REQ(REQ),
    .REG_WR(REG_WR), .SAVERAM_MASK(SAVERAM_MASK), .ROM_MASK(ROM_MASK), .ROM_ADDR(ra1),
    .ROM_HIT(hit1), .IS_SAVERAM(sv1), .ADDR_VALID(av1), .REG_HIT(rh1), .REG_DATA_OUT(rd1),
    .BLOCK_OUT(bo1)
  );

  typedef struct packed {
    int due;
    logic [1:0][23:0] ad;
    logic [1:0] hit;
    logic [1:0] sram;
  } exp_t;

  exp_t pq[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [1:0][23:0] h_ad;
  logic [1:0] h_hit, h_sram;
  logic m_sram [2];
  logic [2:0] m_blk [2][3];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    h_ad = '0;
    h_hit = '0;
    h_sram = '0;
    for (int k = 0; k < 2; k++) begin
      m_sram[k] = 1'b0;
      for (int i = 0; i < 3; i++) m_blk[k][i] = 3'(i);
    end
  endtask

  // Instance k=0 has three windows, k=1 has one.
  function automatic int reg_off(int k, logic [23:0] a);
    int o;
    o = int'(a[15:0]) - 'h4830;
    return (!a[22] && o >= 0 && o <= (k == 1 ? 1 : 3)) ? o : -1;
  endfunction

  function automatic logic [7:0] read_exp(int k, logic [23:0] a);
    int o;
    o = reg_off(k, a);
    if (o < 0) return 8'h00;
    if (o == 0) return {m_sram[k], 7'b0};
    return {5'b0, m_blk[k][o-1]};
  endfunction

  // Returns {is_saveram, hit, address} from the mapping rules.
  function automatic logic [25:0] model(int k, logic [23:0] a);
    int nw, q, b;
    nw = (k == 1) ? 1 : 3;
    q = int'(a[21:20]);
    if (m_sram[k] && SAVERAM_MASK[0] && !a[22] && a[21] && !a[15] && a[14:13] == 2'b11)
      return {2'b11, 24'hE00000 + ({6'b0, a[20:16], a[12:0]} & SAVERAM_MASK)};
    if (a[23:22] == 2'b11 && q == 0) return {2'b01, {3'b0, a[20:0]} & ROM_MASK};
    if (a[23:22] == 2'b11) begin
      b = (q <= nw) ? int'(m_blk[k][q-1]) : q - 1;
      return {2'b01, 24'(((b + 1) % 16) * 32'h100000 + int'(a[19:0])) & ROM_MASK};
    end
    if (!a[22] && a[15]) return {2'b01, {2'b0, a[21:0]} & ROM_MASK};
    return 26'b0;
  endfunction

  function automatic logic [23:0] gen();
    logic [23:0] a;
    a = 24'($urandom);
    case ($urandom_range(0, 4))
      1: a[23:22] = 2'b11;
      2: begin a[22] = 1'b0; a[21] = 1'b1; a[15] = 1'b0; a[14:13] = 2'b11; end
      3: begin a[22] = 1'b0; a[15] = 1'b1; end
      4: begin a[22] = 1'b0; a[15:0] = 16'h4830 + 16'($urandom_range(0, 4)); end
      default: ;
    endcase
    return a;
  endfunction

  task automatic check_all(logic v);
    chk("valid3", av3, v);
    chk("valid1", av1, v);
    chk("addr3", ra3, h_ad[0]);
    chk("addr1", ra1, h_ad[1]);
    chk("hit3", hit3, h_hit[0]);
    chk("hit1", hit1, h_hit[1]);
    chk("sram3", sv3, h_sram[0]);
    chk("sram1", sv1, h_sram[1]);
    chk("reghit3", rh3, reg_off(0, SNES_ADDR) >= 0);
    chk("reghit1", rh1, reg_off(1, SNES_ADDR) >= 0);
    chk("rdata3", rd3, read_exp(0, SNES_ADDR));
    chk("rdata1", rd1, read_exp(1, SNES_ADDR));
    chk("block3", bo3, {m_blk[0][2], m_blk[0][1], m_blk[0][0]});
    chk("block1", bo1, m_blk[1][0]);
  endtask

  task automatic tick();
    exp_t e;
    logic [25:0] r;
    logic v;
    int o;
    @(posedge CLK);
    cyc++;
    if (!RST) begin
      if (REQ) begin
        e.due = cyc + 1;
        for (int k = 0; k < 2; k++) begin
          r = model(k, SNES_ADDR);
          e.ad[k] = r[23:0];
          e.hit[k] = r[24];
          e.sram[k] = r[25];
        end
        pq.push_back(e);
      end
      if (REG_WR)
        for (int k = 0; k < 2; k++) begin
          o = reg_off(k, SNES_ADDR);
          if (o == 0) m_sram[k] = SNES_DATA_IN[7];
          else if (o > 0) m_blk[k][o-1] = SNES_DATA_IN[2:0];
        end
    end
    @(negedge CLK);
    v = pq.size() > 0 && pq[0].due == cyc;
    if (v) begin
      e = pq.pop_front();
      h_ad = e.ad;
      h_hit = e.hit;
      h_sram = e.sram;
    end
    check_all(v);
  endtask

  task automatic req(logic [23:0] a);
    SNES_ADDR = a;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
  endtask

  task automatic wr(logic [23:0] a, logic [7:0] d);
    SNES_ADDR = a;
    SNES_DATA_IN = d;
    REG_WR = 1'b1;
    tick();
    REG_WR = 1'b0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    RST = 1'b0;
    tick();
    req(24'hD01234);
    tick();
    chk("tp_d01234", ra3, 24'h101234);
    chk("tp_d01234_hit", hit3, 1'b1);
    wr(24'h004831, 8'h05);
    req(24'hD00000);
    tick();
    chk("tp_blk5", ra3, 24'h600000);
    req(24'hD00000);
    wr(24'h004831, 8'h00);
    chk("tp_inflight_old", ra3, 24'h600000);
    req(24'hD00000);
    tick();
    chk("tp_blk0", ra3, 24'h100000);
    SNES_ADDR = 24'h004831;
    SNES_DATA_IN = 8'h07;
    REQ = 1'b1;
    REG_WR = 1'b1;
    tick();
    REQ = 1'b0;
    REG_WR = 1'b0;
    req(24'hD00000);
    chk("tp_same_cycle_none", hit3, 1'b0);
    tick();
    chk("tp_blk7", ra3, 24'h800000);
    ROM_MASK = 24'h7FFFFF;
    req(24'hD00000);
    tick();
    chk("tp_blk7_masked", ra3, 24'h000000);
    ROM_MASK = 24'hFFFFFF;
    wr(24'h004830, 8'h80);
    SAVERAM_MASK = 24'h001FFF;
    req(24'h306010);
    tick();
    chk("tp_sram_flag", sv3, 1'b1);
    chk("tp_sram_addr", ra3, 24'hE00010);
    wr(24'h004830, 8'h00);
    req(24'h306010);
    tick();
    chk("tp_sram_off_hit", hit3, 1'b0);
    req(24'hF00000);
    tick();
    chk("tp_fixed_q3", ra1, 24'h300000);
    wr(24'h004833, 8'h05);
    chk("tp_ignore_hit", rh1, 1'b0);
    chk("tp_ignore_blk", bo1, 3'd7);
    SNES_ADDR = 24'hD00000;
    REQ = 1'b1;
    tick();
    SNES_ADDR = 24'hE00000;
    tick();
    SNES_ADDR = 24'hF00000;
    #2 RST = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", av3, 1'b0);
    chk("rst_addr", ra3, 24'h0);
    chk("rst_hit", hit3, 1'b0);
    chk("rst_block3", bo3, 9'b010_001_000);
    chk("rst_block1", bo1, 3'd0);
    tick();
    RST = 1'b0;
    REQ = 1'b0;
    repeat (3) tick();
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 0) begin
        REQ = 1'b0;
        REG_WR = 1'b0;
        tick();
        tick();
        ROM_MASK = 24'((32'd1 << $urandom_range(16, 24)) - 1);
        SAVERAM_MASK = 24'($urandom) & 24'h03FFFF;
      end
      SNES_ADDR = gen();
      SNES_DATA_IN = 8'($urandom);
      REQ = 1'($urandom_range(0, 1));
      REG_WR = ($urandom_range(0, 4) == 0);
      tick();
    end
    REQ = 1'b0;
    REG_WR = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
